frame_sync_ctrl: RTL and testbench
==================================

Name: frame_sync_ctrl

Overview:
- Frame alignment and position sequencer in front of the CRC engine.
- Locks to the FAS marker on the incoming byte stream and runs row/column counters that advance on valid beats only.
- Drives the row/column position, a payload-enable strobe and a CRC-slot strobe to the CRC block, with data, valid and FAS delayed to stay aligned.
- Declares in-frame and loss-of-frame through a hunt/presync/sync state machine.

Parameters:
- NUM_ROWS, 4, rows per frame.
- NUM_COLS, 1041, columns per row (0..1040).
- PAY_START, 16, first payload column.
- PAY_END, 1039, last payload column.
- CRC_ROW, 3, row carrying the CRC byte.
- CRC_COL, 1040, column carrying the CRC byte.
- LOF_THRESH, 3, consecutive missed FAS (in SYNC) that force loss of frame.

Ports:
- i_clk  in  1  system clock.
- i_rst  in  1  asynchronous active-high reset.
- i_frame_data  in  8  line byte.
- i_frame_data_valid  in  1  byte valid; counters advance only when high.
- i_frame_data_fas  in  1  FAS marker; meaningful only with valid.
- o_frame_data  out  8  i_frame_data delayed 1 cycle.
- o_frame_data_valid  out  1  valid delayed 1 cycle.
- o_frame_data_fas  out  1  fas delayed 1 cycle.
- o_row_cnt  out  2  row of the beat on o_frame_data.
- o_col_cnt  out  11  column of the beat on o_frame_data.
- o_payload_en  out  1  payload beat; feeds CRC accumulate.
- o_crc_slot  out  1  CRC beat; feeds CRC insert/check.
- o_frame_start  out  1  beat at (0,0) that anchors a frame.
- o_in_frame  out  1  high in SYNC.
- o_lof  out  1  loss of frame.

Behaviour:
- Reset state:
  - All data/valid/fas/strobe outputs 0.
  - row = col = 0.
  - State HUNT, miss count 0.
  - o_in_frame = 0, o_lof = 1.
  - Reset mid-frame aborts immediately; no partial strobes after reset release.
- Latency and registering:
  - All outputs are registered with 1-cycle latency.
  - Position outputs always describe the beat currently on o_frame_data.
- Position counting:
  - Applies to every valid beat while not in HUNT, unless re-anchored.
  - col increments; at NUM_COLS-1, col wraps to 0 and row increments.
  - At (NUM_ROWS-1, NUM_COLS-1), both wrap to 0.
  - Frame length is 4164 valid beats.
  - Invalid cycles hold the counters and force all strobes low.
- HUNT:
  - Counters held at 0; no strobes; o_in_frame = 0.
  - Valid & fas: that beat is (0,0), o_frame_start = 1, go PRESYNC.
- PRESYNC:
  - Counting and strobes are active.
  - At the expected frame start (valid beat where counters wrap to (0,0)): fas high goes SYNC, clears o_lof and sets o_in_frame; fas low goes HUNT.
  - Valid & fas at any non-(0,0) position re-anchors: the beat becomes (0,0), o_frame_start pulses, stay in PRESYNC.
- SYNC:
  - At each expected frame start, o_frame_start pulses whether or not fas is present.
  - fas high clears the miss count.
  - fas low increments the miss count; reaching LOF_THRESH goes HUNT, sets o_lof, clears o_in_frame and the miss count.
  - fas at an unexpected position is ignored, with no re-anchor.
- Strobes (valid beats only, state PRESYNC or SYNC):
  - o_payload_en = PAY_START ≤ col ≤ PAY_END on any row, giving 4096 per frame.
  - o_crc_slot = (row == CRC_ROW && col == CRC_COL), giving one per frame (beat 4163).
  - o_payload_en and o_crc_slot are mutually exclusive.
- Simultaneous events:
  - Expected wrap plus fas is a match, not a re-anchor.
  - The beat that causes HUNT entry from SYNC still carries position (0,0) and o_frame_start = 1.

Test Plan:
- Reset with stimulus idle → all strobes 0, row/col 0, o_lof = 1, o_in_frame = 0. Assert i_rst at beat 2000 → outputs return to reset values on the next edge with no further strobes.
- Continuous valid, fas at beats 0 and 4164 → o_frame_start at beats 0 and 4164 (+1 cycle). o_in_frame and ~o_lof rise on the beat-4164 output. 4096 o_payload_en pulses and exactly one o_crc_slot (row 3, col 1040) in frame 1.
- Valid deasserted every other cycle → counters freeze on gaps; o_crc_slot still occurs on valid beat 4163; no strobes on invalid cycles.
- In SYNC, drop fas at three consecutive frame starts → o_lof rises and o_in_frame falls after the third miss. Dropping only two, then restoring fas, keeps SYNC.
- In PRESYNC, inject fas at beat 500 → position resets to (0,0) at that beat with o_frame_start. The next match 4164 beats later enters SYNC.
- In SYNC, inject a spurious fas mid-frame → ignored: counters continue and o_frame_start does not pulse.

Source files
------------

// File: rtl/frame_sync_ctrl.sv
// frame_sync_ctrl: FAS frame alignment (hunt/presync/sync) and row/column sequencer feeding the CRC engine
module frame_sync_ctrl #(
    parameter int NUM_ROWS   = 4,
    parameter int NUM_COLS   = 1041,
    parameter int PAY_START  = 16,
    parameter int PAY_END    = 1039,
    parameter int CRC_ROW    = 3,
    parameter int CRC_COL    = 1040,
    parameter int LOF_THRESH = 3
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [7:0]  i_frame_data,
    input  logic        i_frame_data_valid,
    input  logic        i_frame_data_fas,
    output logic [7:0]  o_frame_data,
    output logic        o_frame_data_valid,
    output logic        o_frame_data_fas,
    output logic [1:0]  o_row_cnt,
    output logic [10:0] o_col_cnt,
    output logic        o_payload_en,
    output logic        o_crc_slot,
    output logic        o_frame_start,
    output logic        o_in_frame,
    output logic        o_lof
);
    localparam int          MW       = $clog2(LOF_THRESH + 1);
    localparam logic [1:0]  LAST_ROW = 2'(NUM_ROWS - 1);
    localparam logic [10:0] LAST_COL = 11'(NUM_COLS - 1);
    localparam logic [10:0] P_START  = 11'(PAY_START);
    localparam logic [10:0] P_END    = 11'(PAY_END);
    localparam logic [1:0]  C_ROW    = 2'(CRC_ROW);
    localparam logic [10:0] C_COL    = 11'(CRC_COL);
    localparam logic [MW-1:0] THRESH = MW'(LOF_THRESH);

    typedef enum logic [1:0] {HUNT, PRESYNC, SYNC} state_t;

    state_t        state, state_nxt;
    logic [MW-1:0] miss, miss_nxt, miss_inc;
    logic          fas, wrap, run, anchor, zero;
    logic [1:0]    row_nxt;
    logic [10:0]   col_nxt;
    logic          pay_nxt, crc_nxt;

    assign fas      = i_frame_data_valid && i_frame_data_fas;
    assign wrap     = i_frame_data_valid && o_row_cnt == LAST_ROW && o_col_cnt == LAST_COL;
    assign run      = state != HUNT;
    assign miss_inc = miss + 1'b1;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state <= HUNT;
            miss  <= '0;
        end else begin
            state <= state_nxt;
            miss  <= miss_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        miss_nxt  = miss;
        case (state)
            HUNT:    state_nxt = fas ? PRESYNC : HUNT;
            PRESYNC: state_nxt = wrap ? (fas ? SYNC : HUNT) : PRESYNC;
            SYNC: begin
                if (wrap && fas) miss_nxt = '0;
                if (wrap && !fas) miss_nxt = miss_inc;
                if (wrap && !fas && miss_inc == THRESH) begin
                    state_nxt = HUNT;
                    miss_nxt  = '0;
                end
            end
            default: state_nxt = HUNT;
        endcase
    end

    // SYNC ignores off-position FAS; PRESYNC re-anchors on it
    always_comb begin
        anchor  = run ? (wrap || (state == PRESYNC && fas)) : fas;
        zero    = anchor || !run;
        row_nxt = !i_frame_data_valid ? o_row_cnt :
                  zero ? 2'd0 :
                  o_col_cnt == LAST_COL ? o_row_cnt + 2'd1 : o_row_cnt;
        col_nxt = !i_frame_data_valid ? o_col_cnt :
                  zero ? 11'd0 :
                  o_col_cnt == LAST_COL ? 11'd0 : o_col_cnt + 11'd1;
        pay_nxt = i_frame_data_valid && run && col_nxt >= P_START && col_nxt <= P_END;
        crc_nxt = i_frame_data_valid && run && row_nxt == C_ROW && col_nxt == C_COL;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_frame_data       <= '0;
            o_frame_data_valid <= 1'b0;
            o_frame_data_fas   <= 1'b0;
            o_row_cnt          <= '0;
            o_col_cnt          <= '0;
            o_payload_en       <= 1'b0;
            o_crc_slot         <= 1'b0;
            o_frame_start      <= 1'b0;
        end else begin
            o_frame_data       <= i_frame_data;
            o_frame_data_valid <= i_frame_data_valid;
            o_frame_data_fas   <= i_frame_data_fas;
            o_row_cnt          <= row_nxt;
            o_col_cnt          <= col_nxt;
            o_payload_en       <= pay_nxt;
            o_crc_slot         <= crc_nxt;
            o_frame_start      <= anchor;
        end
    end

    assign o_in_frame = state == SYNC;
    assign o_lof      = state != SYNC;
endmodule

// File: tb/tb_frame_sync_ctrl.sv
// tb_frame_sync_ctrl: directed vector table plus multi-frame sequences for frame_sync_ctrl
module tb_frame_sync_ctrl;
    logic        i_clk = 1'b0;
    logic        i_rst = 1'b0;
    logic [7:0]  i_frame_data = '0;
    logic        i_frame_data_valid = 1'b0;
    logic        i_frame_data_fas = 1'b0;
    logic [7:0]  o_frame_data;
    logic        o_frame_data_valid, o_frame_data_fas;
    logic [1:0]  o_row_cnt;
    logic [10:0] o_col_cnt;
    logic        o_payload_en, o_crc_slot, o_frame_start, o_in_frame, o_lof;

    int n_vec = 0;
    int n_err = 0;
    logic [1:0]  prev_row = '0;
    logic [10:0] prev_col = '0;

    frame_sync_ctrl dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_frame_data(i_frame_data), .i_frame_data_valid(i_frame_data_valid),
        .i_frame_data_fas(i_frame_data_fas),
        .o_frame_data(o_frame_data), .o_frame_data_valid(o_frame_data_valid),
        .o_frame_data_fas(o_frame_data_fas),
        .o_row_cnt(o_row_cnt), .o_col_cnt(o_col_cnt),
        .o_payload_en(o_payload_en), .o_crc_slot(o_crc_slot),
        .o_frame_start(o_frame_start), .o_in_frame(o_in_frame), .o_lof(o_lof)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic        v, f;
        logic [7:0]  d;
        logic [1:0]  r;
        logic [10:0] c;
        logic        p, cr, st, inf, lof;
    } vec_t;

    vec_t tbl[9];

    function automatic logic [26:0] obs();
        return {o_frame_data, o_frame_data_valid, o_row_cnt, o_col_cnt,
                o_payload_en, o_crc_slot, o_frame_start, o_in_frame, o_lof};
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    // called at a negedge: drive a beat, return at the next negedge with its outputs visible
    task automatic beat(input logic v, input logic f, input logic [7:0] d);
        i_frame_data_valid = v;
        i_frame_data_fas   = f;
        i_frame_data       = d;
        @(negedge i_clk);
    endtask

    task automatic do_reset();
        i_rst = 1'b1;
        i_frame_data_valid = 1'b0;
        i_frame_data_fas = 1'b0;
        i_frame_data = '0;
        @(negedge i_clk);
        chk("reset_state", obs(), {8'h0, 1'b0, 2'd0, 11'd0, 3'b000, 1'b0, 1'b1});
        i_rst = 1'b0;
    endtask

    task automatic run_frame(input bit f0, input bit eif, input bit gaps, input int spur, input int n);
        int pay_n = 0;
        int crc_n = 0;
        for (int k = 0; k < n; k++) begin
            int r = k / 1041;
            int c = k % 1041;
            logic ep, ec;
            logic [7:0] d;
            if (gaps) begin
                beat(1'b0, 1'b0, 8'h5A);
                chk($sformatf("gap%0d", k), obs(),
                    {8'h5A, 1'b0, prev_row, prev_col, 3'b000, eif, ~eif});
            end
            ep = c >= 16 && c <= 1039;
            ec = r == 3 && c == 1040;
            d  = k[7:0];
            beat(1'b1, (k == 0) ? f0 : (k == spur), d);
            chk($sformatf("beat%0d", k), obs(),
                {d, 1'b1, 2'(r), 11'(c), ep, ec, k == 0, eif, ~eif});
            pay_n += int'(o_payload_en);
            crc_n += int'(o_crc_slot);
            prev_row = 2'(r);
            prev_col = 11'(c);
        end
        if (n == 4164) begin
            chk("payload_count", pay_n, 4096);
            chk("crc_count", crc_n, 1);
        end
    endtask

    initial begin
        tbl[0] = '{v:0, f:0, d:8'h00, r:0, c:0, p:0, cr:0, st:0, inf:0, lof:1};
        tbl[1] = '{v:1, f:0, d:8'h11, r:0, c:0, p:0, cr:0, st:0, inf:0, lof:1};
        tbl[2] = '{v:1, f:1, d:8'h22, r:0, c:0, p:0, cr:0, st:1, inf:0, lof:1};
        tbl[3] = '{v:1, f:0, d:8'h33, r:0, c:1, p:0, cr:0, st:0, inf:0, lof:1};
        tbl[4] = '{v:0, f:1, d:8'h44, r:0, c:1, p:0, cr:0, st:0, inf:0, lof:1};
        tbl[5] = '{v:1, f:0, d:8'h55, r:0, c:2, p:0, cr:0, st:0, inf:0, lof:1};
        tbl[6] = '{v:1, f:1, d:8'h66, r:0, c:0, p:0, cr:0, st:1, inf:0, lof:1};
        tbl[7] = '{v:1, f:0, d:8'h77, r:0, c:1, p:0, cr:0, st:0, inf:0, lof:1};
        tbl[8] = '{v:1, f:0, d:8'h88, r:0, c:2, p:0, cr:0, st:0, inf:0, lof:1};

        @(negedge i_clk);
        do_reset();
        foreach (tbl[i]) begin
            beat(tbl[i].v, tbl[i].f, tbl[i].d);
            chk($sformatf("tbl%0d", i),
                {o_frame_data, o_frame_data_valid, o_frame_data_fas, o_row_cnt, o_col_cnt,
                 o_payload_en, o_crc_slot, o_frame_start, o_in_frame, o_lof},
                {tbl[i].d, tbl[i].v, tbl[i].f, tbl[i].r, tbl[i].c,
                 tbl[i].p, tbl[i].cr, tbl[i].st, tbl[i].inf, tbl[i].lof});
        end

        // acquisition, gapped frame, then miss counting
        do_reset();
        run_frame(1, 0, 0, -1, 4164);
        run_frame(1, 1, 0, -1, 4164);
        run_frame(1, 1, 1, -1, 4164);
        run_frame(0, 1, 0, -1, 4164);
        run_frame(0, 1, 0, -1, 4164);
        run_frame(1, 1, 0, -1, 4164);
        run_frame(0, 1, 0, -1, 4164);
        run_frame(0, 1, 0, -1, 4164);
        beat(1'b1, 1'b0, 8'hC3);
        chk("third_miss", obs(), {8'hC3, 1'b1, 2'd0, 11'd0, 3'b001, 1'b0, 1'b1});
        for (int i = 0; i < 5; i++) begin
            beat(1'b1, 1'b0, 8'(i));
            chk($sformatf("hunt_hold%0d", i), obs(), {8'(i), 1'b1, 2'd0, 11'd0, 3'b000, 1'b0, 1'b1});
        end

        // reacquire, then a spurious FAS in SYNC must be ignored
        run_frame(1, 0, 0, -1, 4164);
        run_frame(1, 1, 0, 2000, 4164);
        run_frame(1, 1, 0, -1, 5);

        // PRESYNC re-anchor at beat 500, then match
        do_reset();
        run_frame(1, 0, 0, -1, 500);
        run_frame(1, 0, 0, -1, 4164);
        run_frame(1, 1, 0, -1, 5);

        // asynchronous reset at beat 2000
        do_reset();
        run_frame(1, 0, 0, -1, 2000);
        i_frame_data_valid = 1'b1;
        i_frame_data_fas   = 1'b0;
        i_frame_data       = 8'hEE;
        #2 i_rst = 1'b1;
        #1 chk("async_rst", obs(), {8'h0, 1'b0, 2'd0, 11'd0, 3'b000, 1'b0, 1'b1});
        @(negedge i_clk);
        chk("rst_held", obs(), {8'h0, 1'b0, 2'd0, 11'd0, 3'b000, 1'b0, 1'b1});
        i_rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            beat(1'b1, 1'b0, 8'(8'h10 + i));
            chk($sformatf("post_rst%0d", i), obs(),
                {8'(8'h10 + i), 1'b1, 2'd0, 11'd0, 3'b000, 1'b0, 1'b1});
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
